// File: rtl/operand_latch_stage.sv
// Operand-capture buffer between the register file and execute: forwards same-cycle writeback,
// forces r0 to zero, and presents captured operands under valid/ready. Define OPERAND_LATCH_SNOOP_EN
// to also refresh buffered operands from later writebacks.
module operand_latch_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int TAG_W  = 8,
  parameter int DEPTH  = 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [TAG_W-1:0]  In_Tag,
  input  logic [ADDR_W-1:0] A_Address,
  input  logic [ADDR_W-1:0] B_Address,
  input  logic [DATA_W-1:0] A_Data,
  input  logic [DATA_W-1:0] B_Data,
  input  logic              WB_Write,
  input  logic [ADDR_W-1:0] WB_Address,
  input  logic [DATA_W-1:0] WB_Data,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [TAG_W-1:0]  Out_Tag,
  output logic [DATA_W-1:0] Out_A,
  output logic [DATA_W-1:0] Out_B,
  output logic [ADDR_W-1:0] Out_A_Address,
  output logic [ADDR_W-1:0] Out_B_Address
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [ADDR_W-1:0] aadr_q [DEPTH];
  logic [ADDR_W-1:0] badr_q [DEPTH];
  logic [DATA_W-1:0] a_q    [DEPTH];
  logic [DATA_W-1:0] b_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic push, pop, wb_live;
  logic [DATA_W-1:0] cap_a, cap_b;

  assign In_Ready  = (count != CNT_W'(DEPTH));
  assign Out_Valid = (count != '0);
  assign push      = In_Valid & In_Ready;
  assign pop       = Out_Valid & Out_Ready;
  assign wb_live   = WB_Write & (WB_Address != '0);

  always_comb begin
    cap_a = A_Data;
    if (A_Address == '0)
      cap_a = '0;
    else if (wb_live && (WB_Address == A_Address))
      cap_a = WB_Data;

    cap_b = B_Data;
    if (B_Address == '0)
      cap_b = '0;
    else if (wb_live && (WB_Address == B_Address))
      cap_b = WB_Data;
  end

`ifdef OPERAND_LATCH_SNOOP_EN
  logic [PTR_W-1:0] off [DEPTH];
  logic [DEPTH-1:0] snoop_a, snoop_b;

  // An entry is live if it sits within count of the head; the head leaving this edge is excluded.
  always_comb begin
    snoop_a = '0;
    snoop_b = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off[i] = PTR_W'(i) - rd_ptr;
      if (wb_live && ({1'b0, off[i]} < count) && !(pop && (off[i] == '0))) begin
        snoop_a[i] = (aadr_q[i] == WB_Address);
        snoop_b[i] = (badr_q[i] == WB_Address);
      end
    end
  end
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        aadr_q[i] <= '0;
        badr_q[i] <= '0;
        a_q[i]    <= '0;
        b_q[i]    <= '0;
      end
    end else if (Flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
`ifdef OPERAND_LATCH_SNOOP_EN
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (snoop_a[i]) a_q[i] <= WB_Data;
        if (snoop_b[i]) b_q[i] <= WB_Data;
      end
`endif
      if (push) begin
        tag_q[wr_ptr]  <= In_Tag;
        aadr_q[wr_ptr] <= A_Address;
        badr_q[wr_ptr] <= B_Address;
        a_q[wr_ptr]    <= cap_a;
        b_q[wr_ptr]    <= cap_b;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign Out_Tag       = tag_q[rd_ptr];
  assign Out_A         = a_q[rd_ptr];
  assign Out_B         = b_q[rd_ptr];
  assign Out_A_Address = aadr_q[rd_ptr];
  assign Out_B_Address = badr_q[rd_ptr];

endmodule

// File: tb/tb_operand_latch_stage.sv
// Bench for operand_latch_stage: table vectors plus hand sequences, checked by a queue scoreboard
// that models occupancy, capture forwarding and (when OPERAND_LATCH_SNOOP_EN is defined) snooping.
module tb_operand_latch_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_Valid, In_Ready;
  logic [7:0]  In_Tag;
  logic [3:0]  A_Address, B_Address;
  logic [31:0] A_Data, B_Data;
  logic        WB_Write;
  logic [3:0]  WB_Address;
  logic [31:0] WB_Data;
  logic        Flush;
  logic        Out_Valid, Out_Ready;
  logic [7:0]  Out_Tag;
  logic [31:0] Out_A, Out_B;
  logic [3:0]  Out_A_Address, Out_B_Address;

  operand_latch_stage #(.DATA_W(32), .ADDR_W(4), .TAG_W(8), .DEPTH(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Tag(In_Tag),
    .A_Address(A_Address), .B_Address(B_Address), .A_Data(A_Data), .B_Data(B_Data),
    .WB_Write(WB_Write), .WB_Address(WB_Address), .WB_Data(WB_Data), .Flush(Flush),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Tag(Out_Tag), .Out_A(Out_A),
    .Out_B(Out_B), .Out_A_Address(Out_A_Address), .Out_B_Address(Out_B_Address)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        vld;
    logic [7:0]  tag;
    logic [3:0]  aa;
    logic [31:0] ad;
    logic [3:0]  ba;
    logic [31:0] bd;
    logic        wbw;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic        ordy;
    logic        flush;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  typedef struct {
    logic [7:0]  tag;
    logic [3:0]  aa;
    logic [3:0]  ba;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;

  ent_t q[$];
  ent_t exp_in;
  bit   mon_en = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cap(input logic [3:0] adr, input logic [31:0] d,
                                      input logic wbw, input logic [3:0] wba, input logic [31:0] wbd);
    if (adr == 4'd0) return 32'd0;
    if (wbw && wba == adr) return wbd;
    return d;
  endfunction

  function automatic vec_t mk(input logic vld, input logic [7:0] tag,
                              input logic [3:0] aa, input logic [31:0] ad,
                              input logic [3:0] ba, input logic [31:0] bd,
                              input logic wbw, input logic [3:0] wba, input logic [31:0] wbd,
                              input logic ordy, input logic flush);
    vec_t v;
    v = '{vld, tag, aa, ad, ba, bd, wbw, wba, wbd, ordy, flush,
          cap(aa, ad, wbw, wba, wbd), cap(ba, bd, wbw, wba, wbd)};
    return v;
  endfunction

  task automatic drv(input vec_t v);
    In_Valid   = v.vld;
    In_Tag     = v.tag;
    A_Address  = v.aa;
    A_Data     = v.ad;
    B_Address  = v.ba;
    B_Data     = v.bd;
    WB_Write   = v.wbw;
    WB_Address = v.wba;
    WB_Data    = v.wbd;
    Out_Ready  = v.ordy;
    Flush      = v.flush;
    exp_in     = '{v.tag, v.aa, v.ba, v.exp_a, v.exp_b};
  endtask

  task automatic apply(input vec_t v);
    @(posedge Clk);
    #1;
    drv(v);
  endtask

  task automatic idle(input logic ordy);
    apply(mk(1'b0, 8'h0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, ordy, 1'b0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d entries left expected 0", q.size());
    end
  endtask

  // Scoreboard: compare head against model, then advance the model across the coming edge.
  always @(negedge Clk) begin
    if (mon_en) begin
      ent_t e;
      chk("in_ready", 32'(In_Ready), 32'(q.size() < 2));
      chk("out_valid", 32'(Out_Valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
        chk("out_tag", 32'(Out_Tag), 32'(q[0].tag));
        chk("out_a_addr", 32'(Out_A_Address), 32'(q[0].aa));
        chk("out_b_addr", 32'(Out_B_Address), 32'(q[0].ba));
        chk("out_a", Out_A, q[0].a);
        chk("out_b", Out_B, q[0].b);
      end
      if (Flush) begin
        q.delete();
      end else begin
        bit do_pop, do_push;
        do_pop  = Out_Ready && q.size() != 0;
        do_push = In_Valid && q.size() < 2;
`ifdef OPERAND_LATCH_SNOOP_EN
        if (WB_Write && WB_Address != 4'd0) begin
          for (int i = 0; i < q.size(); i++) begin
            e = q[i];
            if (e.aa == WB_Address) e.a = WB_Data;
            if (e.ba == WB_Address) e.b = WB_Data;
            q[i] = e;
          end
        end
`endif
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(exp_in);
      end
    end
  end

  initial begin
    tbl[0] = '{1'b1, 8'h10, 4'd3, 32'h11, 4'd0, 32'h55, 1'b1, 4'd3, 32'hAA, 1'b1, 1'b0,
               32'hAA, 32'h0};
    tbl[1] = '{1'b1, 8'h11, 4'd1, 32'h1234, 4'd2, 32'h5678, 1'b0, 4'd1, 32'hFFFF, 1'b1, 1'b0,
               32'h1234, 32'h5678};
    tbl[2] = '{1'b1, 8'h12, 4'd7, 32'h1, 4'd9, 32'h2, 1'b1, 4'd9, 32'hDEADBEEF, 1'b1, 1'b0,
               32'h1, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 8'h13, 4'd6, 32'h3, 4'd6, 32'h4, 1'b1, 4'd6, 32'hCAFEF00D, 1'b1, 1'b0,
               32'hCAFEF00D, 32'hCAFEF00D};
    tbl[4] = '{1'b1, 8'h14, 4'd0, 32'hFFFFFFFF, 4'd0, 32'hFFFFFFFF, 1'b1, 4'd0, 32'h12, 1'b1, 1'b0,
               32'h0, 32'h0};
    tbl[5] = '{1'b1, 8'h15, 4'd15, 32'h80000000, 4'd14, 32'h7FFFFFFF, 1'b1, 4'd13, 32'h1, 1'b1, 1'b0,
               32'h80000000, 32'h7FFFFFFF};
    tbl[6] = '{1'b1, 8'hFF, 4'd15, 32'h0, 4'd15, 32'h0, 1'b1, 4'd15, 32'hFFFFFFFF, 1'b1, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[7] = '{1'b1, 8'h00, 4'd2, 32'hA5A5A5A5, 4'd0, 32'h5A5A5A5A, 1'b0, 4'd2, 32'h9, 1'b1, 1'b0,
               32'hA5A5A5A5, 32'h0};
    tbl[8] = '{1'b0, 8'h00, 4'd0, 32'h0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0, 1'b1, 1'b0,
               32'h0, 32'h0};

    // Reset held two cycles with a pending request.
    Rst_n = 1'b0;
    drv(mk(1'b1, 8'h99, 4'd4, 32'h44, 4'd8, 32'h88, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0));
    for (int c = 0; c < 2; c++) begin
      @(negedge Clk);
      chk("rst_out_valid", 32'(Out_Valid), 32'd0);
      chk("rst_in_ready", 32'(In_Ready), 32'd1);
      chk("rst_out_a", Out_A, 32'd0);
      chk("rst_out_b", Out_B, 32'd0);
      chk("rst_out_tag", 32'(Out_Tag), 32'd0);
    end
    @(posedge Clk);
    #1;
    Rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 9; i++) apply(tbl[i]);
    drain();

    // Backpressure: third request must be refused while full.
    apply(mk(1'b1, 8'd1, 4'd1, 32'h101, 4'd2, 32'h102, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(1'b1, 8'd2, 4'd3, 32'h201, 4'd4, 32'h202, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(1'b1, 8'd3, 4'd5, 32'h301, 4'd6, 32'h302, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    @(negedge Clk);
    chk("full_in_ready", 32'(In_Ready), 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    drain();

    // Streaming push/pop across pointer wrap.
    for (int t = 1; t <= 6; t++)
      apply(mk(1'b1, 8'(t), 4'(t), 32'(t * 16), 4'(t + 8), 32'(t * 256), 1'b0, 4'd0, 32'd0,
               1'b1, 1'b0));
    idle(1'b1);
    drain();

    // Flush with concurrent push discards everything.
    apply(mk(1'b1, 8'h21, 4'd1, 32'h21, 4'd2, 32'h22, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(1'b1, 8'h22, 4'd3, 32'h23, 4'd4, 32'h24, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(1'b1, 8'h23, 4'd5, 32'h25, 4'd6, 32'h26, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1));
    idle(1'b0);
    @(negedge Clk);
    chk("flush_out_valid", 32'(Out_Valid), 32'd0);
    apply(mk(1'b1, 8'h24, 4'd7, 32'h27, 4'd8, 32'h28, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0));
    idle(1'b1);
    drain();

    // Stalled head vs later writeback to its A register.
    apply(mk(1'b1, 8'h30, 4'd5, 32'h10, 4'd1, 32'h20, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0));
    apply(mk(1'b0, 8'h0, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, 4'd5, 32'h77, 1'b0, 1'b0));
    idle(1'b0);
    @(negedge Clk);
`ifdef OPERAND_LATCH_SNOOP_EN
    chk("snoop_head_a", Out_A, 32'h77);
`else
    chk("snoop_head_a", Out_A, 32'h10);
`endif
    apply(mk(1'b1, 8'h31, 4'd5, 32'h99, 4'd5, 32'h98, 1'b1, 4'd5, 32'h66, 1'b0, 1'b0));
    idle(1'b1);
    idle(1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
